// File: rtl/lms_weight_update.sv
// Serial LMS update, one tap per clock: w[k] <= sat(w[k] + ((e*x[k]) >>> MU_SHIFT)); 16 edges after accept, done pulses on the last.
// No backpressure: start while busy is dropped, adap_filter_state low aborts the pass, preload only lands in IDLE.
module lms_weight_update #(
  parameter int NTAP     = 16,
  parameter int MU_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        adap_filter_state,
  input  logic        start,
  input  logic [9:0]  e,
  input  logic [13:0] reff_0,
  input  logic [13:0] reff_1,
  input  logic [13:0] reff_2,
  input  logic [13:0] reff_3,
  input  logic [13:0] reff_4,
  input  logic [13:0] reff_5,
  input  logic [13:0] reff_6,
  input  logic [13:0] reff_7,
  input  logic [13:0] reff_8,
  input  logic [13:0] reff_9,
  input  logic [13:0] reff_10,
  input  logic [13:0] reff_11,
  input  logic [13:0] reff_12,
  input  logic [13:0] reff_13,
  input  logic [13:0] reff_14,
  input  logic [13:0] reff_15,
  input  logic        weight_ld,
  input  logic [3:0]  weight_ld_idx,
  input  logic [30:0] weight_ld_data,
  output logic [30:0] weight_in_0,
  output logic [30:0] weight_in_1,
  output logic [30:0] weight_in_2,
  output logic [30:0] weight_in_3,
  output logic [30:0] weight_in_4,
  output logic [30:0] weight_in_5,
  output logic [30:0] weight_in_6,
  output logic [30:0] weight_in_7,
  output logic [30:0] weight_in_8,
  output logic [30:0] weight_in_9,
  output logic [30:0] weight_in_10,
  output logic [30:0] weight_in_11,
  output logic [30:0] weight_in_12,
  output logic [30:0] weight_in_13,
  output logic [30:0] weight_in_14,
  output logic [30:0] weight_in_15,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [9:0]  e_q;
  logic [13:0] x_q  [NTAP];
  logic [13:0] reff [NTAP];
  logic [30:0] w_q  [NTAP];

  logic signed [23:0] e_ext, x_ext, prod, shifted;
  logic        [30:0] w_sel, w_sat;
  logic        [31:0] sum;

  assign reff[0]  = reff_0;   assign reff[1]  = reff_1;
  assign reff[2]  = reff_2;   assign reff[3]  = reff_3;
  assign reff[4]  = reff_4;   assign reff[5]  = reff_5;
  assign reff[6]  = reff_6;   assign reff[7]  = reff_7;
  assign reff[8]  = reff_8;   assign reff[9]  = reff_9;
  assign reff[10] = reff_10;  assign reff[11] = reff_11;
  assign reff[12] = reff_12;  assign reff[13] = reff_13;
  assign reff[14] = reff_14;  assign reff[15] = reff_15;

  assign weight_in_0  = w_q[0];   assign weight_in_1  = w_q[1];
  assign weight_in_2  = w_q[2];   assign weight_in_3  = w_q[3];
  assign weight_in_4  = w_q[4];   assign weight_in_5  = w_q[5];
  assign weight_in_6  = w_q[6];   assign weight_in_7  = w_q[7];
  assign weight_in_8  = w_q[8];   assign weight_in_9  = w_q[9];
  assign weight_in_10 = w_q[10];  assign weight_in_11 = w_q[11];
  assign weight_in_12 = w_q[12];  assign weight_in_13 = w_q[13];
  assign weight_in_14 = w_q[14];  assign weight_in_15 = w_q[15];

  // 24-bit product never overflows (10b x 14b); 32-bit sum of 24b and 31b cannot wrap,
  // so a mismatch between bits 31 and 30 means the result left the 31-bit range.
  always_comb begin
    e_ext   = {{14{e_q[9]}}, e_q};
    x_ext   = {{10{x_q[idx][13]}}, x_q[idx]};
    prod    = e_ext * x_ext;
    shifted = prod >>> MU_SHIFT;
    w_sel   = w_q[idx];
    sum     = {{8{shifted[23]}}, shifted} + {w_sel[30], w_sel};
    w_sat   = sum[30:0];
    if (sum[31] != sum[30])
      w_sat = sum[31] ? 31'h40000000 : 31'h3FFFFFFF;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      e_q   <= '0;
      for (int k = 0; k < NTAP; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (weight_ld) begin
            w_q[weight_ld_idx] <= weight_ld_data;
          end else if (start && adap_filter_state) begin
            e_q <= e;
            for (int k = 0; k < NTAP; k++) x_q[k] <= reff[k];
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!adap_filter_state) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            w_q[idx] <= w_sat;
            idx      <= idx + 4'd1;
            if (idx == 4'(NTAP - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update: one instance at MU_SHIFT=4, one at MU_SHIFT=0, shared inputs.
module tb_lms_weight_update;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic adap = 1'b0;
  logic start = 1'b0;
  logic [9:0] e = '0;
  logic [15:0][13:0] reff = '0;
  logic weight_ld = 1'b0;
  logic [3:0] weight_ld_idx = '0;
  logic [30:0] weight_ld_data = '0;
  logic [15:0][30:0] w4, w0;
  logic busy4, done4, busy0, done0;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  lms_weight_update #(.NTAP(16), .MU_SHIFT(4)) dut4 (
    .clk(clk), .rstn(rstn), .adap_filter_state(adap), .start(start), .e(e),
    .reff_0(reff[0]), .reff_1(reff[1]), .reff_2(reff[2]), .reff_3(reff[3]),
    .reff_4(reff[4]), .reff_5(reff[5]), .reff_6(reff[6]), .reff_7(reff[7]),
    .reff_8(reff[8]), .reff_9(reff[9]), .reff_10(reff[10]), .reff_11(reff[11]),
    .reff_12(reff[12]), .reff_13(reff[13]), .reff_14(reff[14]), .reff_15(reff[15]),
    .weight_ld(weight_ld), .weight_ld_idx(weight_ld_idx), .weight_ld_data(weight_ld_data),
    .weight_in_0(w4[0]), .weight_in_1(w4[1]), .weight_in_2(w4[2]), .weight_in_3(w4[3]),
    .weight_in_4(w4[4]), .weight_in_5(w4[5]), .weight_in_6(w4[6]), .weight_in_7(w4[7]),
    .weight_in_8(w4[8]), .weight_in_9(w4[9]), .weight_in_10(w4[10]), .weight_in_11(w4[11]),
    .weight_in_12(w4[12]), .weight_in_13(w4[13]), .weight_in_14(w4[14]), .weight_in_15(w4[15]),
    .busy(busy4), .done(done4)
  );

  lms_weight_update #(.NTAP(16), .MU_SHIFT(0)) dut0 (
    .clk(clk), .rstn(rstn), .adap_filter_state(adap), .start(start), .e(e),
    .reff_0(reff[0]), .reff_1(reff[1]), .reff_2(reff[2]), .reff_3(reff[3]),
    .reff_4(reff[4]), .reff_5(reff[5]), .reff_6(reff[6]), .reff_7(reff[7]),
    .reff_8(reff[8]), .reff_9(reff[9]), .reff_10(reff[10]), .reff_11(reff[11]),
    .reff_12(reff[12]), .reff_13(reff[13]), .reff_14(reff[14]), .reff_15(reff[15]),
    .weight_ld(weight_ld), .weight_ld_idx(weight_ld_idx), .weight_ld_data(weight_ld_data),
    .weight_in_0(w0[0]), .weight_in_1(w0[1]), .weight_in_2(w0[2]), .weight_in_3(w0[3]),
    .weight_in_4(w0[4]), .weight_in_5(w0[5]), .weight_in_6(w0[6]), .weight_in_7(w0[7]),
    .weight_in_8(w0[8]), .weight_in_9(w0[9]), .weight_in_10(w0[10]), .weight_in_11(w0[11]),
    .weight_in_12(w0[12]), .weight_in_13(w0[13]), .weight_in_14(w0[14]), .weight_in_15(w0[15]),
    .busy(busy0), .done(done0)
  );

  typedef struct {
    string       name;
    bit          rst;
    bit          mu0;
    bit          ld;
    logic [3:0]  ld_idx;
    logic [30:0] ld_dat;
    logic [9:0]  e;
    int          sel;
    logic [13:0] x_sel;
    int          aux;
    logic [30:0] exp_sel;
    logic [30:0] exp_aux;
    logic [30:0] exp_oth;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_all_reff(input logic [13:0] v);
    for (int k = 0; k < 16; k++) reff[k] = v;
  endtask

  // Pulse start and wait (bounded) for done on the chosen instance.
  task automatic run_pass(input string nm, input bit mu0);
    bit seen;
    seen = 1'b0;
    adap = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = mu0 ? done0 : done4;
    end
    check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{"signed",   1'b1, 1'b0, 1'b0, 4'd0, 31'd0, 10'h3F0, 3, 14'h3FF8, 3, 31'd8, 31'd8, 31'd0};
    tbl[1] = '{"floor_m1", 1'b0, 1'b0, 1'b0, 4'd0, 31'd0, 10'h3FF, 0, 14'd1, 3, 31'h7FFFFFFF, 31'd8, 31'd0};
    tbl[2] = '{"floor_m15",1'b1, 1'b0, 1'b0, 4'd0, 31'd0, 10'h3FD, 7, 14'd5, 7, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'd0};
    tbl[3] = '{"trunc_p21",1'b0, 1'b0, 1'b0, 4'd0, 31'd0, 10'd7, 9, 14'd3, 7, 31'd1, 31'h7FFFFFFF, 31'd0};
    tbl[4] = '{"sat_pos",  1'b1, 1'b1, 1'b1, 4'd5, 31'h3FFFFFF0, 10'h1FF, 5, 14'h1FFF, 5, 31'h3FFFFFFF, 31'h3FFFFFFF, 31'd0};
    tbl[5] = '{"sat_neg",  1'b1, 1'b1, 1'b1, 4'd5, 31'h40000010, 10'h200, 5, 14'h1FFF, 5, 31'h40000000, 31'h40000000, 31'd0};

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    for (int k = 0; k < 16; k++) check($sformatf("rst_w%0d", k), {1'b0, w4[k]}, 32'd0);
    do_reset();

    // Basic cycle-accurate pass, snapshot, busy rejection, re-accept at T+17
    e = 10'd16;
    set_all_reff(14'd100);
    adap = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 10'h200;
    set_all_reff(14'h1FFF);
    check("acc_busy", {31'd0, busy4}, 32'd1);
    check("acc_w0", {1'b0, w4[0]}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == 4) begin
        start = 1'b1;
        e = 10'd100;
      end
      tick();
      start = 1'b0;
      check($sformatf("basic_w%0d", k), {1'b0, w4[k]}, 32'd100);
      if (k < 15) begin
        check($sformatf("basic_busy%0d", k), {31'd0, busy4}, 32'd1);
        check($sformatf("basic_done%0d", k), {31'd0, done4}, 32'd0);
        check($sformatf("basic_next_w%0d", k + 1), {1'b0, w4[k + 1]}, 32'd0);
      end else begin
        check("basic_busy_end", {31'd0, busy4}, 32'd0);
        check("basic_done_end", {31'd0, done4}, 32'd1);
      end
    end
    e = 10'd16;
    set_all_reff(14'd100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reacc_done_low", {31'd0, done4}, 32'd0);
    check("reacc_busy", {31'd0, busy4}, 32'd1);
    for (int i = 0; i < 40 && !done4; i++) tick();
    check("reacc_w0", {1'b0, w4[0]}, 32'd200);
    check("reacc_w15", {1'b0, w4[15]}, 32'd200);

    // Abort sampled at the edge meant for tap 7
    do_reset();
    e = 10'd16;
    set_all_reff(14'd100);
    adap = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    adap = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_done", {31'd0, done4}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("abort_done_hold%0d", i), {31'd0, done4}, 32'd0);
    end
    for (int k = 0; k < 16; k++)
      check($sformatf("abort_w%0d", k), {1'b0, w4[k]}, (k < 7) ? 32'd100 : 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_adap_low_blocks", {31'd0, busy4}, 32'd0);
    adap = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_then_idle_accept", {31'd0, busy4}, 32'd1);

    // Reset mid-update right after tap 8 is written
    do_reset();
    adap = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_w8", {1'b0, w4[8]}, 32'd100);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy4}, 32'd0);
    check("mid_rst_done", {31'd0, done4}, 32'd0);
    check("mid_rst_w0", {1'b0, w4[0]}, 32'd0);
    check("mid_rst_w8", {1'b0, w4[8]}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_pass("post_rst", 1'b0);
    for (int k = 0; k < 16; k++) check($sformatf("post_rst_w%0d", k), {1'b0, w4[k]}, 32'd100);

    // Preload and start on the same edge: preload wins
    tick();
    weight_ld = 1'b1;
    weight_ld_idx = 4'd2;
    weight_ld_data = 31'h123;
    start = 1'b1;
    tick();
    weight_ld = 1'b0;
    start = 1'b0;
    check("ld_wins_busy", {31'd0, busy4}, 32'd0);
    check("ld_wins_w2", {1'b0, w4[2]}, 32'h123);

    // Table-driven single-pass vectors
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].rst) do_reset();
      tick();
      if (tbl[v].ld) begin
        weight_ld = 1'b1;
        weight_ld_idx = tbl[v].ld_idx;
        weight_ld_data = tbl[v].ld_dat;
        tick();
        weight_ld = 1'b0;
      end
      e = tbl[v].e;
      set_all_reff(14'd0);
      reff[tbl[v].sel] = tbl[v].x_sel;
      run_pass(tbl[v].name, tbl[v].mu0);
      for (int k = 0; k < 16; k++) begin
        logic [30:0] exp_w, act_w;
        exp_w = (k == tbl[v].sel) ? tbl[v].exp_sel :
                (k == tbl[v].aux) ? tbl[v].exp_aux : tbl[v].exp_oth;
        act_w = tbl[v].mu0 ? w0[k] : w4[k];
        check($sformatf("%s_w%0d", tbl[v].name, k), {1'b0, act_w}, {1'b0, exp_w});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/lms_weight_update.md
Name: lms_weight_update

Overview:
- Serial LMS coefficient-update engine; closes the loop around the 16-tap adaptive filter datapath.
- Consumes the filter's error sample and the 16 reference taps used for that output; produces the 16 weight buses the filter multiplies against.
- Updates one tap per clock: w[k] <= sat(w[k] + ((e*x[k]) >>> MU_SHIFT)).

Parameters:
- NTAP, 16, number of taps; fixed at 16 in this release.
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT, applied as an arithmetic right shift of the product.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- adap_filter_state  in  1  adaptation enable; low aborts any update and blocks start.
- start  in  1  one-cycle pulse: e and reff_k are valid now.
- e  in  10  error sample, two's complement.
- reff_0..reff_15  in  14 each  reference taps, two's complement.
- weight_ld  in  1  preload strobe; honoured only in IDLE.
- weight_ld_idx  in  4  tap index for preload.
- weight_ld_data  in  31  preload value.
- weight_in_0..weight_in_15  out  31 each  current weights, two's complement, registered.
- busy  out  1  high while taps are being updated.
- done  out  1  one-cycle pulse after tap 15 is written.

Behaviour:
- Reset (async, rstn=0): all weights 0, state IDLE, idx 0, busy 0, done 0, snapshot registers 0. Reset mid-update discards the remainder; weights return to 0.
- States: IDLE, UPDATE.
  - IDLE -> UPDATE on posedge with start=1 and adap_filter_state=1.
  - UPDATE -> IDLE on the edge that writes idx=15, or on any edge with adap_filter_state=0 (abort).
- Accept edge T: snapshot e and all 16 reff_k into internal registers, set idx=0, busy=1. Inputs may change after T.
- Edges T+1..T+16 write taps 0..15 in order, one per edge, using the snapshot values.
- At edge T+16: busy=0, done=1 for exactly one cycle.
- start is accepted again from edge T+17 onward. start while busy is ignored, with no queueing.
- Arithmetic:
  - product = e * x[k], signed 24-bit.
  - Arithmetic right shift by MU_SHIFT; rounds toward minus infinity.
  - Sign-extend to 32 bits and add to w[k].
  - Saturate the sum to [-2^30, 2^30-1], i.e. 0x40000000 .. 0x3FFFFFFF.
- Abort (adap_filter_state=0 during UPDATE):
  - Tap at the current idx is not written on that edge.
  - Taps already written keep their new values; remaining taps are unchanged.
  - busy=0 at that edge; done is not asserted.
- Preload:
  - weight_ld=1 in IDLE writes weight_ld_data to tap weight_ld_idx on that edge.
  - weight_ld is ignored in UPDATE.
  - If weight_ld and an accepted start fall on the same edge, the preload wins and start is dropped.
- adap_filter_state=0 in IDLE: weights hold their values.
- weight_in_k changes only on its own update edge, a preload, or reset.

Test Plan:
- Basic update: reset, MU_SHIFT=4, e=16, all reff_k=100, start at edge T -> busy high T+1..T+16; weight_in_k=100 from edge T+1+k; done=1 only in the cycle after T+16.
- Signed and rounding:
  - e=-16, reff_3=-8, others 0 -> weight_in_3=8, all other taps 0.
  - Second pass with e=-1, reff_0=1 -> weight_in_0=-1 (0x7FFFFFFF), since floor shift of -1 gives -1.
- Saturation:
  - MU_SHIFT=0; preload tap 5 with 0x3FFFFFF0; e=511, reff_5=8191 -> weight_in_5=0x3FFFFFFF.
  - Mirror case with preload 0x40000010 and e=-512 -> 0x40000000.
- Abort: start, then drop adap_filter_state so it is sampled low at the edge intended for tap 7 -> taps 0..6 updated, taps 7..15 unchanged, no done pulse, state IDLE.
- Busy rejection and snapshot: start again at T+5 with different e and reff, and change reff mid-run -> second start ignored; results use the values captured at T only; new start at T+17 accepted.
- Reset mid-update: deassert rstn at tap 9 -> all weights 0, busy=0, done=0 immediately; a normal run after release produces the basic-update values.
